// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the instruction/data memory arbiter.
package mem_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_I = 2'd1,
      BUSY_D = 2'd2
   } arb_state_t;

   localparam int unsigned STARVE_LIMIT_DEFAULT = 4;
   localparam int unsigned STARVE_CNT_W         = 4;

   // Saturating increment used by the fetch-starvation counter.
   function automatic logic [STARVE_CNT_W-1:0] sat_inc(
      input logic [STARVE_CNT_W-1:0] value,
      input logic [STARVE_CNT_W-1:0] limit
   );
      return (value >= limit) ? limit : value + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arbiter.sv
// Shares one backing memory port between fetch and data requesters.
// Data wins contention until fetch has been passed over STARVE_LIMIT times.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int ADDR_W       = 32,
   parameter int DATA_W       = 32,
   parameter int STARVE_LIMIT = STARVE_LIMIT_DEFAULT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_done,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_wr,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_done,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              busy
);

   localparam logic [STARVE_CNT_W-1:0] LIMIT = STARVE_CNT_W'(STARVE_LIMIT);

   arb_state_t              state;
   logic [STARVE_CNT_W-1:0] starve_cnt;
   logic [DATA_W-1:0]       i_hold;
   logic [DATA_W-1:0]       d_hold;
   logic                    d_grant;

   assign d_grant = d_req & (~i_req | (starve_cnt < LIMIT));
   assign busy    = (state != IDLE);

   // Completion pulses and read-data bypass; reset suppresses a done in flight.
   always_comb begin
      i_done  = ~rst & (state == BUSY_I) & mem_ready;
      d_done  = ~rst & (state == BUSY_D) & mem_ready;
      i_rdata = i_done ? mem_rdata : i_hold;
      d_rdata = (d_done & ~mem_wr) ? mem_rdata : d_hold;
   end

   // Arbitration FSM, request latch, starvation counter and rdata hold registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         starve_cnt <= '0;
         mem_req    <= 1'b0;
         mem_wr     <= 1'b0;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         i_hold     <= '0;
         d_hold     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (d_grant) begin
                  state      <= BUSY_D;
                  mem_req    <= 1'b1;
                  mem_wr     <= d_wr;
                  mem_addr   <= d_addr;
                  mem_wdata  <= d_wdata;
                  starve_cnt <= i_req ? sat_inc(starve_cnt, LIMIT) : '0;
               end else if (i_req) begin
                  state      <= BUSY_I;
                  mem_req    <= 1'b1;
                  mem_wr     <= 1'b0;
                  mem_addr   <= i_addr;
                  starve_cnt <= '0;
               end else begin
                  starve_cnt <= '0;
               end
            end
            BUSY_I: begin
               if (mem_ready) begin
                  i_hold  <= mem_rdata;
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  if (!mem_wr) begin
                     d_hold <= mem_rdata;
                  end
                  mem_req <= 1'b0;
                  state   <= IDLE;
               end
            end
            default: begin
               state   <= IDLE;
               mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// compared every cycle against a transaction-level reference model.
module tb_mem_arbiter;

   localparam int AW    = 32;
   localparam int DW    = 32;
   localparam int LIMIT = 4;
   localparam byte G_I  = 8'h49;
   localparam byte G_D  = 8'h44;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          i_req = 1'b0;
   logic [AW-1:0] i_addr = '0;
   logic          i_done;
   logic [DW-1:0] i_rdata;
   logic          d_req = 1'b0;
   logic          d_wr = 1'b0;
   logic [AW-1:0] d_addr = '0;
   logic [DW-1:0] d_wdata = '0;
   logic          d_done;
   logic [DW-1:0] d_rdata;
   logic          mem_req;
   logic          mem_wr;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          mem_ready = 1'b0;
   logic [DW-1:0] mem_rdata = '0;
   logic          busy;

   always #5 clk = ~clk;

   mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(LIMIT)) dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_done(i_done), .i_rdata(i_rdata),
      .d_req(d_req), .d_wr(d_wr), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_done(d_done), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_wr(mem_wr), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .busy(busy)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: who owns the memory, what was latched, held read data.
   typedef enum {OWN_NONE, OWN_I, OWN_D} own_t;
   own_t          m_own;
   int            m_cnt;
   logic          m_req, m_wr;
   logic [AW-1:0] m_addr;
   logic [DW-1:0] m_wdata, m_ihold, m_dhold;
   logic [DW-1:0] ref_mem   [logic [AW-1:0]];
   logic [DW-1:0] bench_mem [logic [AW-1:0]];
   byte           grant_log [$];
   bit            saw_idone, saw_ddone;
   int            n_done = 0;

   function automatic logic [DW-1:0] dflt(input logic [AW-1:0] a);
      return a ^ 32'hA5A5_0F0F;
   endfunction

   function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
   endfunction

   function automatic logic [DW-1:0] bench_rd(input logic [AW-1:0] a);
      return bench_mem.exists(a) ? bench_mem[a] : dflt(a);
   endfunction

   task automatic model_reset();
      m_own = OWN_NONE; m_cnt = 0; m_req = 0; m_wr = 0;
      m_addr = '0; m_wdata = '0; m_ihold = '0; m_dhold = '0;
   endtask

   // One clock: check outputs at negedge, advance model, drive memory data after posedge.
   task automatic step();
      logic          e_id, e_dd;
      logic [DW-1:0] e_ir, e_dr;
      @(negedge clk);
      check("mem_req", mem_req, m_req);
      check("busy", busy, m_own != OWN_NONE);
      check("mem_addr", mem_addr, m_addr);
      check("mem_wr", mem_wr, m_wr);
      check("mem_wdata", mem_wdata, m_wdata);
      e_id = !rst && (m_own == OWN_I) && mem_ready;
      e_dd = !rst && (m_own == OWN_D) && mem_ready;
      e_ir = e_id ? ref_rd(m_addr) : m_ihold;
      e_dr = (e_dd && !m_wr) ? ref_rd(m_addr) : m_dhold;
      check("i_done", i_done, e_id);
      check("d_done", d_done, e_dd);
      check("i_rdata", i_rdata, e_ir);
      check("d_rdata", d_rdata, e_dr);
      saw_idone = e_id;
      saw_ddone = e_dd;
      if (e_id || e_dd) n_done++;
      if (!rst && mem_req && mem_ready && mem_wr) bench_mem[mem_addr] = mem_wdata;
      if (rst) begin
         model_reset();
      end else if (m_own == OWN_NONE) begin
         if (d_req && (!i_req || m_cnt < LIMIT)) begin
            m_own = OWN_D; m_req = 1; m_wr = d_wr; m_addr = d_addr; m_wdata = d_wdata;
            m_cnt = i_req ? ((m_cnt + 1 > LIMIT) ? LIMIT : m_cnt + 1) : 0;
            grant_log.push_back(G_D);
         end else if (i_req) begin
            m_own = OWN_I; m_req = 1; m_wr = 0; m_addr = i_addr; m_cnt = 0;
            grant_log.push_back(G_I);
         end else begin
            m_cnt = 0;
         end
      end else if (mem_ready) begin
         if (m_own == OWN_I) m_ihold = ref_rd(m_addr);
         else if (m_wr) ref_mem[m_addr] = m_wdata;
         else m_dhold = ref_rd(m_addr);
         m_own = OWN_NONE; m_req = 0;
      end
      @(posedge clk);
      #1;
      mem_rdata = bench_rd(mem_addr);
   endtask

   task automatic go_idle();
      i_req = 0; d_req = 0; d_wr = 0; mem_ready = 0;
      repeat (3) step();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      string exp_s;
      bit    f_pend, d_pend;

      model_reset();
      repeat (2) @(posedge clk);
      #1;
      step();                       // reset values checked under rst
      rst = 0;
      go_idle();

      // Fetch only, one-cycle memory.
      bench_mem[32'h40] = 32'hDEADBEEF;
      ref_mem[32'h40]   = 32'hDEADBEEF;
      i_req = 1; i_addr = 32'h40;
      step();
      check("fetch_mem_req", mem_req, 1);
      mem_ready = 1;
      step();
      check("fetch_done", saw_idone, 1);
      i_req = 0; mem_ready = 0;
      repeat (2) step();
      check("fetch_hold", i_rdata, 32'hDEADBEEF);

      // Store then load.
      d_req = 1; d_wr = 1; d_addr = 32'h100; d_wdata = 32'h12345678;
      step();
      check("store_wr", mem_wr, 1);
      check("store_wdata", mem_wdata, 32'h12345678);
      mem_ready = 1;
      step();
      check("store_done", saw_ddone, 1);
      check("store_no_rdata", d_rdata, 32'h0);
      d_wr = 0; d_wdata = '0;
      step();
      step();
      check("load_done", saw_ddone, 1);
      d_req = 0; mem_ready = 0;
      step();
      check("load_rdata", d_rdata, 32'h12345678);
      go_idle();

      // Contention with immediate memory: D,D,D,D,I repeating.
      grant_log.delete();
      i_req = 1; i_addr = 32'h200; d_req = 1; d_wr = 0; d_addr = 32'h104;
      mem_ready = 1;
      repeat (20) step();
      exp_s = "DDDDIDDDDI";
      check("contention_count", grant_log.size() >= 10, 1);
      for (int k = 0; k < 10 && k < grant_log.size(); k++)
         check($sformatf("contention_%0d", k), grant_log[k], exp_s[k]);
      go_idle();

      // Wait states: three cycles without mem_ready.
      i_req = 1; i_addr = 32'h40;
      step();
      for (int k = 0; k < 3; k++) begin
         step();
         check("ws_busy", busy, 1);
         check("ws_mem_req", mem_req, 1);
         check("ws_addr", mem_addr, 32'h40);
         check("ws_no_done", saw_idone, 0);
      end
      mem_ready = 1;
      step();
      check("ws_done", saw_idone, 1);
      go_idle();

      // Reset mid-access with starve count at the limit.
      grant_log.delete();
      i_req = 1; i_addr = 32'h200; d_req = 1; d_wr = 1; d_addr = 32'h108; d_wdata = 32'hCAFE0001;
      mem_ready = 1;
      repeat (6) step();
      mem_ready = 0;
      step();                       // fourth data grant, counter saturated
      step();
      check("rst_pre_busy", busy, 1);
      rst = 1;
      step();
      check("rst_idle", busy, 0);
      check("rst_mem_req", mem_req, 0);
      rst = 0; mem_ready = 1;       // late mem_ready lands in IDLE
      step();
      check("rst_late_no_done", saw_ddone, 0);
      check("rst_cnt_cleared", grant_log[grant_log.size()-1], G_D);
      mem_ready = 0;
      step();
      mem_ready = 1; i_req = 0; d_req = 0;
      step();
      go_idle();

      // Random traffic.
      f_pend = 0; d_pend = 0; n_done = 0;
      for (int c = 0; c < 1500; c++) begin
         if (saw_idone) f_pend = 0;
         if (saw_ddone) d_pend = 0;
         if (!f_pend && ($urandom % 3 == 0)) begin
            f_pend = 1;
            i_addr = 32'h300 + 32'($urandom_range(0, 7)) * 4;
         end
         if (!d_pend && ($urandom % 2 == 0)) begin
            d_pend  = 1;
            d_addr  = 32'h300 + 32'($urandom_range(0, 7)) * 4;
            d_wr    = $urandom % 2;
            d_wdata = $urandom;
         end
         i_req = f_pend;
         d_req = d_pend;
         mem_ready = ($urandom % 3 == 0);
         step();
      end
      i_req = 0; d_req = 0; mem_ready = 1;
      repeat (4) step();
      check("rand_progress", n_done > 50, 1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
